input_debouncer: RTL

- Upstream conditioning stage for the positive edge detector.
- Takes a raw, asynchronous, bouncy input (button or external pin) and synchronises it into the clock domain.
- Accepts a new level only after it has been stable for a programmable number of cycles, then drives the clean level onto the edge detector's data input.
- Counts rejected glitches so software and the bench can see bounce activity.

---
 rtl/edge_pkg.sv | 14 +
 rtl/sync_ff.sv | 23 ++
 rtl/input_debouncer.sv | 112 +++++++++++
 3 files changed

// File: rtl/edge_pkg.sv
// Shared types and defaults for the input conditioning and edge detection path.
package edge_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW,
    CHECK_HIGH,
    IDLE_HIGH,
    CHECK_LOW
  } debounce_state_t;

  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned STABLE_CYCLES_DEF = 4;

endpackage

// File: rtl/sync_ff.sv
// N-stage flop synchroniser for an asynchronous single-bit pin, reusable for any input.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[STAGES-2:0], d};
    end
  end

  assign q = stages[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronises a bouncy raw input and accepts a new level only after it has held
// for STABLE_CYCLES cycles; rejected candidates are strobed and counted.
module input_debouncer
  import edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned GLITCH_W      = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                raw_in,
  output logic                data_out,
  output logic                glitch,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic            sync;
  debounce_state_t state;
  logic [CNT_W-1:0] cnt;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (raw_in),
    .q       (sync)
  );

  // Debounce FSM, stability counter and saturating glitch counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE_LOW;
      cnt          <= '0;
      data_out     <= 1'b0;
      glitch       <= 1'b0;
      glitch_count <= '0;
    end else begin
      glitch <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (sync) begin
            if (STABLE_CYCLES == 1) begin
              state    <= IDLE_HIGH;
              data_out <= 1'b1;
            end else begin
              state <= CHECK_HIGH;
              cnt   <= CNT_W'(1);
            end
          end
        end
        CHECK_HIGH: begin
          if (sync) begin
            if (cnt == CNT_LAST) begin
              state    <= IDLE_HIGH;
              cnt      <= '0;
              data_out <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            state  <= IDLE_LOW;
            cnt    <= '0;
            glitch <= 1'b1;
            if (glitch_count != '1) begin
              glitch_count <= glitch_count + GLITCH_W'(1);
            end
          end
        end
        IDLE_HIGH: begin
          if (!sync) begin
            if (STABLE_CYCLES == 1) begin
              state    <= IDLE_LOW;
              data_out <= 1'b0;
            end else begin
              state <= CHECK_LOW;
              cnt   <= CNT_W'(1);
            end
          end
        end
        CHECK_LOW: begin
          if (!sync) begin
            if (cnt == CNT_LAST) begin
              state    <= IDLE_LOW;
              cnt      <= '0;
              data_out <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            state  <= IDLE_HIGH;
            cnt    <= '0;
            glitch <= 1'b1;
            if (glitch_count != '1) begin
              glitch_count <= glitch_count + GLITCH_W'(1);
            end
          end
        end
        default: begin
          state    <= IDLE_LOW;
          cnt      <= '0;
          data_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
